// File: rtl/voice_activity_gate_if.sv
// Sample stream between the voice activity gate and the audio-processing stage.
// The master side is the gate; the slave side supplies adc_data and consumes samples.
interface voice_activity_gate_if;
   logic [11:0] adc_data;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic        frame_start;
   logic        frame_last;
   logic        busy;

   modport master (
      input  adc_data,
      output sample_out, sample_valid, frame_start, frame_last, busy
   );

   modport slave (
      output adc_data,
      input  sample_out, sample_valid, frame_start, frame_last, busy
   );
endinterface

// File: rtl/voice_activity_gate.sv
// Energy-triggered utterance gate: samples the ADC, removes DC, forwards one fixed-length capture per trigger.
// Optional macro VAD_DC_TRACK_EN replaces the fixed 2048 offset with a tracked 12.8 fixed-point estimate.
module voice_activity_gate #(
   parameter int CLK_DIV      = 6250,
   parameter int WIN_LEN      = 256,
   parameter int ENERGY_TH    = 65536,
   parameter int TRIG_WINS    = 2,
   parameter int CAPTURE_LEN  = 16000,
   parameter int HOLDOFF_WINS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   voice_activity_gate_if.master       vag
);
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WIN_W  = $clog2(WIN_LEN);
   localparam int ACC_W  = 11 + WIN_W;
   localparam int EN_W   = ACC_W + 1;
   localparam int TRIG_W = $clog2(TRIG_WINS + 1);
   localparam int CAP_W  = $clog2(CAPTURE_LEN + 1);
   localparam int HOLD_W = $clog2(HOLDOFF_WINS + 2);

   typedef enum logic [1:0] {IDLE, CAPTURE, HOLDOFF} state_t;

   logic [DIV_W-1:0]  div_cnt_reg;
   logic [WIN_W-1:0]  win_cnt_reg;
   logic [ACC_W-1:0]  acc_reg;
   logic              win_end_reg, win_hot_reg;
   logic              strobe, win_last;
   logic [11:0]       x, abs_x;
   logic [EN_W-1:0]   energy;

   state_t            state_reg, state_next;
   logic [TRIG_W-1:0] trig_cnt_reg, trig_cnt_next;
   logic [CAP_W-1:0]  cap_cnt_reg, cap_cnt_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic              busy_reg, busy_next;
   logic [11:0]       sample_out_reg, sample_out_next;
   logic              sample_valid_reg, sample_valid_next;
   logic              frame_start_reg, frame_start_next;
   logic              frame_last_reg, frame_last_next;

   assign strobe   = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
   assign win_last = (win_cnt_reg == WIN_W'(WIN_LEN - 1));

`ifdef VAD_DC_TRACK_EN
   logic [19:0]        dc_reg;
   logic signed [20:0] dc_err;
   logic signed [12:0] x_wide;

   assign dc_err = $signed({1'b0, vag.adc_data, 8'd0}) - $signed({1'b0, dc_reg});
   assign x_wide = $signed({1'b0, vag.adc_data}) - $signed({1'b0, dc_reg[19:8]});
   assign x      = (x_wide[12] != x_wide[11]) ? (x_wide[12] ? 12'h800 : 12'h7ff) : x_wide[11:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dc_reg <= 20'h80000;
      end else if (strobe) begin
         dc_reg <= dc_reg + 20'(dc_err >>> 8);
      end
   end
`else
   // adc - 2048 is just the offset-binary to two's-complement flip
   assign x = {~vag.adc_data[11], vag.adc_data[10:0]};
`endif

   assign abs_x = x[11] ? (~x + 12'd1) : x;
   // The full-window sum can reach 2048*WIN_LEN, so the final add gets one extra bit
   assign energy = EN_W'(acc_reg) + EN_W'(abs_x);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_reg <= '0;
         win_cnt_reg <= '0;
         acc_reg     <= '0;
         win_end_reg <= 1'b0;
         win_hot_reg <= 1'b0;
      end else begin
         win_end_reg <= 1'b0;
         if (strobe) begin
            div_cnt_reg <= '0;
            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
            if (win_last) begin
               acc_reg     <= '0;
               win_end_reg <= 1'b1;
               win_hot_reg <= 32'(energy) > 32'(ENERGY_TH);
            end else begin
               acc_reg <= acc_reg + ACC_W'(abs_x);
            end
         end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= IDLE;
         trig_cnt_reg     <= '0;
         cap_cnt_reg      <= '0;
         hold_cnt_reg     <= '0;
         busy_reg         <= 1'b0;
         sample_out_reg   <= '0;
         sample_valid_reg <= 1'b0;
         frame_start_reg  <= 1'b0;
         frame_last_reg   <= 1'b0;
      end else begin
         state_reg        <= state_next;
         trig_cnt_reg     <= trig_cnt_next;
         cap_cnt_reg      <= cap_cnt_next;
         hold_cnt_reg     <= hold_cnt_next;
         busy_reg         <= busy_next;
         sample_out_reg   <= sample_out_next;
         sample_valid_reg <= sample_valid_next;
         frame_start_reg  <= frame_start_next;
         frame_last_reg   <= frame_last_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      trig_cnt_next     = trig_cnt_reg;
      cap_cnt_next      = cap_cnt_reg;
      hold_cnt_next     = hold_cnt_reg;
      busy_next         = busy_reg;
      sample_out_next   = sample_out_reg;
      sample_valid_next = 1'b0;
      frame_start_next  = 1'b0;
      frame_last_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (win_end_reg) begin
               if (!win_hot_reg) begin
                  trig_cnt_next = '0;
               end else if (32'(trig_cnt_reg) + 32'd1 >= 32'(TRIG_WINS)) begin
                  trig_cnt_next = '0;
                  state_next    = CAPTURE;
               end else begin
                  trig_cnt_next = trig_cnt_reg + TRIG_W'(1);
               end
            end
         end
         CAPTURE: begin
            if (strobe) begin
               sample_valid_next = 1'b1;
               sample_out_next   = x;
               busy_next         = 1'b1;
               frame_start_next  = (cap_cnt_reg == '0);
               cap_cnt_next      = cap_cnt_reg + CAP_W'(1);
               if (cap_cnt_reg == CAP_W'(CAPTURE_LEN - 1)) begin
                  frame_last_next = 1'b1;
                  cap_cnt_next    = '0;
                  // the window already in progress counts as the first holdoff window
                  hold_cnt_next   = HOLD_W'(1);
                  state_next      = HOLDOFF;
               end
            end
         end
         HOLDOFF: begin
            if (win_end_reg) begin
               if (32'(hold_cnt_reg) + 32'd1 >= 32'(HOLDOFF_WINS)) begin
                  hold_cnt_next = '0;
                  busy_next     = 1'b0;
                  state_next    = IDLE;
               end else begin
                  hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign vag.sample_out   = sample_out_reg;
   assign vag.sample_valid = sample_valid_reg;
   assign vag.frame_start  = frame_start_reg;
   assign vag.frame_last   = frame_last_reg;
   assign vag.busy         = busy_reg;
endmodule

// File: tb/tb_voice_activity_gate.sv
// Scoreboard bench for voice_activity_gate: a sample-level reference model queues expected pulses,
// an independent negedge monitor pops and compares them and checks busy every cycle.
module tb_voice_activity_gate;
   localparam int CLK_DIV      = 4;
   localparam int WIN_LEN      = 8;
   localparam int ENERGY_TH    = 4000;
   localparam int TRIG_WINS    = 2;
   localparam int CAPTURE_LEN  = 20;
   localparam int HOLDOFF_WINS = 2;

   typedef struct {
      int n;
      int val;
      bit first;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   voice_activity_gate_if vag_bus();

   voice_activity_gate #(
      .CLK_DIV(CLK_DIV), .WIN_LEN(WIN_LEN), .ENERGY_TH(ENERGY_TH),
      .TRIG_WINS(TRIG_WINS), .CAPTURE_LEN(CAPTURE_LEN), .HOLDOFF_WINS(HOLDOFF_WINS)
   ) dut (
      .clk(clk),
      .rst(rst_n),
      .vag(vag_bus)
   );

   int checks = 0;
   int errors = 0;
   int edge_cnt;
   exp_t exp_q[$];

   // reference model state, advanced once per issued sample
   int m_n, m_win_sum, m_hot, m_cap_left, m_hold_end_w, m_rise;
   bit m_open;
   int busy_rise_q[$];
   int busy_fall_q[$];

   int obs_start_q[$];
   int pulse_cnt;
   exp_t mon_e;
   bit   mon_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   function automatic bit busy_expected(input int e);
      if (m_open && e >= m_rise) return 1'b1;
      foreach (busy_rise_q[i])
         if (e >= busy_rise_q[i] && e < busy_fall_q[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         mon_busy = busy_expected(edge_cnt);
         checks++;
         if (vag_bus.busy !== mon_busy) begin
            errors++;
            $display("FAIL busy edge=%0d got=%0b exp=%0b", edge_cnt, vag_bus.busy, mon_busy);
         end
         if (vag_bus.sample_valid === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (vag_bus.frame_start === 1'b1) obs_start_q.push_back(edge_cnt);
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pulse unexpected edge=%0d out=%0d exp=none", edge_cnt,
                        $signed(vag_bus.sample_out));
            end else begin
               mon_e = exp_q.pop_front();
               $display("tx sample=%0d edge=%0d out=%0d start=%0b last=%0b", mon_e.n, edge_cnt,
                        $signed(vag_bus.sample_out), vag_bus.frame_start, vag_bus.frame_last);
               if (edge_cnt != CLK_DIV * mon_e.n ||
                   int'($signed(vag_bus.sample_out)) != mon_e.val ||
                   vag_bus.frame_start !== mon_e.first || vag_bus.frame_last !== mon_e.last) begin
                  errors++;
                  $display("FAIL pulse got edge=%0d out=%0d start=%0b last=%0b exp edge=%0d out=%0d start=%0b last=%0b",
                           edge_cnt, $signed(vag_bus.sample_out), vag_bus.frame_start, vag_bus.frame_last,
                           CLK_DIV * mon_e.n, mon_e.val, mon_e.first, mon_e.last);
               end
            end
         end else if (vag_bus.frame_start !== 1'b0 || vag_bus.frame_last !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_marker edge=%0d got start=%0b last=%0b exp 0 0", edge_cnt,
                     vag_bus.frame_start, vag_bus.frame_last);
         end
      end
   end

   // Issue one sample and advance the model by the rules: window energy, trigger run, capture, holdoff.
   task automatic issue_sample(input int v);
      int x, a, w;
      m_n++;
      x = v - 2048;
      a = (x < 0) ? -x : x;
      m_win_sum += a;
      if (m_cap_left > 0) begin
         exp_q.push_back('{n: m_n, val: x, first: (m_cap_left == CAPTURE_LEN), last: (m_cap_left == 1)});
         if (m_cap_left == CAPTURE_LEN) begin
            m_rise = CLK_DIV * m_n;
            m_open = 1'b1;
         end
         m_cap_left--;
         if (m_cap_left == 0) begin
            w = (m_n - 1) / WIN_LEN + 1;
            m_hold_end_w = w + ((HOLDOFF_WINS > 1) ? HOLDOFF_WINS - 1 : 1) - 1;
            busy_rise_q.push_back(m_rise);
            busy_fall_q.push_back(CLK_DIV * m_hold_end_w * WIN_LEN + 1);
            m_open = 1'b0;
         end
      end else if (m_n % WIN_LEN == 0 && m_n / WIN_LEN > m_hold_end_w) begin
         if (m_win_sum > ENERGY_TH) begin
            m_hot++;
            if (m_hot == TRIG_WINS) begin
               m_hot = 0;
               m_cap_left = CAPTURE_LEN;
            end
         end else begin
            m_hot = 0;
         end
      end
      if (m_n % WIN_LEN == 0) m_win_sum = 0;
      vag_bus.adc_data = 12'(v);
      repeat (CLK_DIV) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      vag_bus.adc_data = 12'd2048;
      repeat (2) @(negedge clk);
      checks++;
      if (vag_bus.sample_out !== 12'd0 || vag_bus.sample_valid !== 1'b0 || vag_bus.frame_start !== 1'b0 ||
          vag_bus.frame_last !== 1'b0 || vag_bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got out=%0h v=%0b s=%0b l=%0b b=%0b exp all 0", vag_bus.sample_out,
                  vag_bus.sample_valid, vag_bus.frame_start, vag_bus.frame_last, vag_bus.busy);
      end
      exp_q.delete();
      busy_rise_q.delete();
      busy_fall_q.delete();
      obs_start_q.delete();
      m_n = 0; m_win_sum = 0; m_hot = 0; m_cap_left = 0; m_hold_end_w = 0; m_rise = 0; m_open = 1'b0;
      pulse_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic end_scenario(input string name);
      while (m_cap_left > 0) issue_sample(2048);
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got pending=%0d exp 0", name, exp_q.size());
      end
      $display("scenario %s done pulses=%0d", name, pulse_cnt);
   endtask

   task automatic run_square(input int hi, input int lo, input int count);
      for (int i = 0; i < count; i++) issue_sample((i % 2 == 0) ? hi : lo);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic check_starts(input string name, input int s0, input int s1, input int n);
      check_int({name, "_nstarts"}, obs_start_q.size(), n);
      if (obs_start_q.size() >= 1) check_int({name, "_start0"}, obs_start_q[0], s0);
      if (n > 1 && obs_start_q.size() >= 2) check_int({name, "_start1"}, obs_start_q[1], s1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int loud_left, v;
      vag_bus.adc_data = 12'd2048;

      do_reset();
      repeat (200) issue_sample(2048);
      end_scenario("silence");
      check_int("silence_pulses", pulse_cnt, 0);

      do_reset();
      run_square(2560, 1536, 40);
      end_scenario("square");
      check_int("square_pulses", pulse_cnt, CAPTURE_LEN);
      check_starts("square", CLK_DIV * 17, 0, 1);

      do_reset();
      run_square(2548, 1548, 80);
      end_scenario("threshold");
      check_int("threshold_pulses", pulse_cnt, 0);

      do_reset();
      run_square(2560, 1536, 8);
      repeat (16) issue_sample(2048);
      run_square(2560, 1536, 8);
      repeat (16) issue_sample(2048);
      end_scenario("single_window");
      check_int("single_window_pulses", pulse_cnt, 0);

      do_reset();
      run_square(2560, 1536, 80);
      end_scenario("retrigger");
      check_int("retrigger_pulses", pulse_cnt, 2 * CAPTURE_LEN);
      check_starts("retrigger", CLK_DIV * 17, CLK_DIV * 57, 2);

      do_reset();
      run_square(2560, 1536, 26);
      check_int("midcap_pulses_before", pulse_cnt, 9);
      check_int("midcap_pulse10_valid", int'(vag_bus.sample_valid), 1);
      rst_n = 1'b0;
      #1;
      check_int("midcap_reset_out", int'(vag_bus.sample_out), 0);
      check_int("midcap_reset_strobes",
                int'({vag_bus.sample_valid, vag_bus.frame_start, vag_bus.frame_last, vag_bus.busy}), 0);
      do_reset();
      run_square(2560, 1536, 40);
      end_scenario("after_reset");
      check_int("after_reset_pulses", pulse_cnt, CAPTURE_LEN);
      check_starts("after_reset", CLK_DIV * 17, 0, 1);

      do_reset();
      loud_left = 0;
      for (int i = 0; i < 400; i++) begin
         if (loud_left == 0 && $urandom_range(0, 30) == 0) loud_left = int'($urandom_range(4, 40));
         if (loud_left > 0) begin
            loud_left--;
            case ($urandom_range(0, 9))
               0:       v = 0;
               1:       v = 4095;
               default: v = ($urandom_range(0, 1) == 1) ? 2048 + int'($urandom_range(300, 1500))
                                                        : 2048 - int'($urandom_range(300, 1500));
            endcase
         end else begin
            v = 2028 + int'($urandom_range(0, 40));
         end
         issue_sample(v);
      end
      end_scenario("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
